mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Shares the single line-wide wishbone memory port between the I-cache and D-cache
//  miss/writeback paths (split-cache LC-3b datapath).
//  Each cache's cache_to_mem master connects to one requester side.
//  Physical memory connects to the mem side.
//  Picks one requester and latches its request. Runs one memory transaction, then
//  returns the registered response to that requester only.
// PARAMETERS
//  ADDR_W  16   address width; bits [2:0] forced to 0 on mem side (line aligned)
//  LINE_W  128  line data width (matches lc3b_c_line)
// PORTS
//  clk         in   1       system clock
//  rst_n       in   1       synchronous active-low reset
//  i_cyc/i_stb in   1/1     I-cache request
//  i_we        in   1       I-cache write (writeback)
//  i_adr       in   ADDR_W  I-cache line address
//  i_dat_m     in   LINE_W  I-cache write line
//  i_ack       out  1       I-cache completion, 1-cycle pulse
//  i_dat_s     out  LINE_W  I-cache read line
//  d_*         same set as i_*, for the D-cache
//  mem_cyc/mem_stb out 1/1  memory request
//  mem_we      out  1       memory write
//  mem_adr     out  ADDR_W  latched address, low 3 bits zero
//  mem_dat_m   out  LINE_W  latched write line
//  mem_ack     in   1       memory completion
//  mem_dat_s   in   LINE_W  memory read line
// BEHAVIOUR
//  Reset: synchronous, active-low, single clock.
//   - State goes to IDLE; last_grant goes to I (so D wins the first tie).
//   - All outputs are 0, including the dat_s and latch registers.
//  States:
//   - IDLE -> BUSY when any (x_cyc & x_stb); the request is latched at that edge.
//   - BUSY -> RESP on mem_ack; mem_dat_s is captured into the granted x_dat_s register.
//   - RESP -> IDLE unconditionally.
//  Timing:
//   - Request sampled in IDLE at cycle n -> mem_cyc/mem_stb high from n+1.
//   - mem_ack at cycle m -> granted x_ack high for exactly cycle m+1, with x_dat_s valid.
//   - Minimum turnaround is 3 cycles/transaction; there are no back-to-back grants.
//  Handshake:
//   - The requester holds cyc/stb until its ack. The latched copy is used during BUSY, so
//     requester input changes after grant are ignored.
//   - The non-granted requester's ack stays 0 and its dat_s holds its last value.
//  Arbitration (only in IDLE):
//   - One requester: it is granted.
//   - Both requesting: the one not equal to last_grant wins (round-robin).
//   - last_grant updates on the IDLE->BUSY edge.
//  Boundaries:
//   - Request withdrawn before sampling: no grant.
//   - New request during BUSY/RESP: waits, never lost, while held.
//   - mem_ack in IDLE/RESP: ignored.
//   - rst_n low mid-BUSY: mem_stb drops the next cycle; the transaction is abandoned with
//     no ack to either side.
//  Widths:
//   - mem_adr = latched_adr & ~ADDR_W'(7).
//   - No arithmetic other than the 1-bit last_grant toggle.
// CONFIGURATION
//  ARB_DCACHE_PRIO_EN
//   - Defined: fixed priority. D wins every tie and last_grant is unused. Note that a
//     continuous D stream can starve I.
//   - Undefined (default): round-robin as above.
// STRUCTURE
//  lc3b_types gains:
//   - enum lc3b_arb_state {ARB_IDLE, ARB_BUSY, ARB_RESP}
//   - enum lc3b_arb_req {ARB_I, ARB_D}
//  lc3b_c_line is reused for line data.
//  One sub-module, arb_pick (combinational):
//   - Inputs: i_req, d_req, last_grant.
//   - Outputs: grant_valid, grant_id.
//   - The macro lives here only.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles -> all outputs 0, state IDLE.
//  2. Lone I read, adr 16'h1236:
//     - mem_adr=16'h1230 and mem_stb=1 one cycle after sampling.
//     - mem_ack with dat 128'hA5..A5 -> i_ack=1 next cycle with i_dat_s=A5..A5.
//     - d_ack stays 0 throughout.
//  3. Simultaneous I and D requests from reset (default build):
//     - D is granted first, then I.
//     - Repeat with both still requesting -> order D,I,D,I.
//     - With ARB_DCACHE_PRIO_EN -> D,D,D while D keeps requesting.
//  4. D write, adr 16'h4008, dat_m 128'h1:
//     - mem_we=1 and mem_dat_m=128'h1.
//     - D changes d_adr during BUSY -> mem_adr stays 16'h4008.
//  5. I request arrives while D is BUSY -> I granted in the IDLE cycle after D's RESP;
//     no ack is dropped or duplicated.
//  6. Stray or abandoned transactions:
//     - rst_n=0 mid-BUSY, then mem_ack -> no x_ack.
//     - mem_ack pulsed in IDLE -> ignored.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the split-cache memory arbiter: arbiter state, requester id and line data.
package mem_arbiter_pkg;

  localparam int unsigned LC3B_LINE_W = 128;

  typedef logic [LC3B_LINE_W-1:0] lc3b_c_line;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } lc3b_arb_state;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } lc3b_arb_req;

  // The single-bit round-robin toggle: the requester that did not win last time.
  function automatic lc3b_arb_req arb_other(input lc3b_arb_req r);
    return (r == ARB_I) ? ARB_D : ARB_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Line-wide wishbone bus between a cache and the arbiter, or between the arbiter and memory.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128
);

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [LINE_W-1:0] dat_m;
  logic              ack;
  logic [LINE_W-1:0] dat_s;

  modport master (
    output cyc,
    output stb,
    output we,
    output adr,
    output dat_m,
    input  ack,
    input  dat_s
  );

  modport slave (
    input  cyc,
    input  stb,
    input  we,
    input  adr,
    input  dat_m,
    output ack,
    output dat_s
  );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational requester selection. ARB_DCACHE_PRIO_EN selects fixed D-cache priority;
// otherwise ties alternate round-robin against last_grant.
module arb_pick
  import mem_arbiter_pkg::*;
(
  input  logic        i_req,
  input  logic        d_req,
  input  lc3b_arb_req last_grant,
  output logic        grant_valid,
  output lc3b_arb_req grant_id
);

  assign grant_valid = i_req | d_req;

`ifdef ARB_DCACHE_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // A continuous D-cache stream starves the I-cache in this mode.
  assign grant_id = d_req ? ARB_D : ARB_I;
`else
  always_comb begin
    grant_id = ARB_I;
    if (i_req && d_req) begin
      grant_id = arb_other(last_grant);
    end else if (d_req) begin
      grant_id = ARB_D;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory port between the I-cache and D-cache; one transaction at a time.
// Build option ARB_DCACHE_PRIO_EN (see arb_pick) switches tie-breaking to fixed D priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = LC3B_LINE_W
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  i_bus,
  mem_arbiter_if.slave  d_bus,
  mem_arbiter_if.master mem_bus
);

  lc3b_arb_state     state_q, state_d;
  lc3b_arb_req       last_grant_q, last_grant_d;
  lc3b_arb_req       grant_q, grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [LINE_W-1:0] dat_m_q, dat_m_d;
  logic              i_ack_q, i_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [LINE_W-1:0] i_dat_s_q, i_dat_s_d;
  logic [LINE_W-1:0] d_dat_s_q, d_dat_s_d;

  logic              i_req;
  logic              d_req;
  logic              grant_valid;
  lc3b_arb_req       grant_id;

  assign i_req = i_bus.cyc & i_bus.stb;
  assign d_req = d_bus.cyc & d_bus.stb;

  arb_pick u_arb_pick (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_m_d      = dat_m_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    i_dat_s_d    = i_dat_s_q;
    d_dat_s_d    = d_dat_s_q;

    unique case (state_q)
      ARB_IDLE: begin
        // The request is copied here so requester changes during BUSY cannot leak to memory.
        if (grant_valid) begin
          state_d      = ARB_BUSY;
          grant_d      = grant_id;
          last_grant_d = grant_id;
          if (grant_id == ARB_D) begin
            we_d    = d_bus.we;
            adr_d   = d_bus.adr;
            dat_m_d = d_bus.dat_m;
          end else begin
            we_d    = i_bus.we;
            adr_d   = i_bus.adr;
            dat_m_d = i_bus.dat_m;
          end
        end
      end
      ARB_BUSY: begin
        if (mem_bus.ack) begin
          state_d = ARB_RESP;
          if (grant_q == ARB_D) begin
            d_ack_d   = 1'b1;
            d_dat_s_d = mem_bus.dat_s;
          end else begin
            i_ack_d   = 1'b1;
            i_dat_s_d = mem_bus.dat_s;
          end
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= ARB_I;
      grant_q      <= ARB_I;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_m_q      <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_dat_s_q    <= '0;
      d_dat_s_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_m_q      <= dat_m_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      i_dat_s_q    <= i_dat_s_d;
      d_dat_s_q    <= d_dat_s_d;
    end
  end

  assign mem_bus.cyc   = (state_q == ARB_BUSY);
  assign mem_bus.stb   = (state_q == ARB_BUSY);
  assign mem_bus.we    = we_q;
  assign mem_bus.adr   = adr_q & ~ADDR_W'(7);
  assign mem_bus.dat_m = dat_m_q;

  assign i_bus.ack   = i_ack_q;
  assign i_bus.dat_s = i_dat_s_q;
  assign d_bus.ack   = d_ack_q;
  assign d_bus.dat_s = d_dat_s_q;

endmodule
